// File: rtl/m68k_cache_ctrl_param_if.sv
// Bus bundle between the TG68 bus, the SDRAM controller, the cache RAMs and
// the cache controller. The slave view belongs to the controller; the master
// view belongs to whatever surrounds it.
interface m68k_cache_ctrl_param_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 16,
    parameter int INDEX_BITS = 9,
    parameter int WORD_BITS  = 3
);
    localparam int TAG_W = ADDR_W - INDEX_BITS - WORD_BITS - 1;

    logic                  Flush_H;
    logic                  FlushBusy_H;
    logic                  CacheHit_H;
    logic                  ValidBitIn_H;
    logic                  DramSelect68k_H;
    logic [ADDR_W-1:0]     AddressBusInFrom68k;
    logic [DATA_W-1:0]     DataBusInFrom68k;
    logic [DATA_W-1:0]     DataBusOutTo68k;
    logic                  UDS_L;
    logic                  LDS_L;
    logic                  WE_L;
    logic                  AS_L;
    logic                  DtackFromDram_L;
    logic                  CAS_Dram_L;
    logic                  RAS_Dram_L;
    logic [DATA_W-1:0]     DataBusInFromDram;
    logic [DATA_W-1:0]     DataBusInFromCache;
    logic [DATA_W-1:0]     DataBusOutToDramController;
    logic [DATA_W-1:0]     DataBusOutToCache;
    logic                  UDS_DramController_L;
    logic                  LDS_DramController_L;
    logic                  WE_DramController_L;
    logic                  AS_DramController_L;
    logic                  DramSelectFromCache_L;
    logic                  DtackTo68k_L;
    logic                  TagCache_WE_L;
    logic                  DataCache_WE_L;
    logic                  ValidBit_WE_L;
    logic [1:0]            DataCache_ByteEn_L;
    logic [ADDR_W-1:0]     AddressBusOutToDramController;
    logic [TAG_W-1:0]      TagDataOut;
    logic [INDEX_BITS-1:0] Index;
    logic [WORD_BITS-1:0]  WordAddress;
    logic                  ValidBitOut_H;
    logic [3:0]            CacheState;

    modport slave (
        input  Flush_H, CacheHit_H, ValidBitIn_H, DramSelect68k_H,
               AddressBusInFrom68k, DataBusInFrom68k, UDS_L, LDS_L, WE_L, AS_L,
               DtackFromDram_L, CAS_Dram_L, RAS_Dram_L,
               DataBusInFromDram, DataBusInFromCache,
        output FlushBusy_H, DataBusOutTo68k, DataBusOutToDramController,
               DataBusOutToCache, UDS_DramController_L, LDS_DramController_L,
               WE_DramController_L, AS_DramController_L, DramSelectFromCache_L,
               DtackTo68k_L, TagCache_WE_L, DataCache_WE_L, ValidBit_WE_L,
               DataCache_ByteEn_L, AddressBusOutToDramController, TagDataOut,
               Index, WordAddress, ValidBitOut_H, CacheState
    );

    modport master (
        output Flush_H, CacheHit_H, ValidBitIn_H, DramSelect68k_H,
               AddressBusInFrom68k, DataBusInFrom68k, UDS_L, LDS_L, WE_L, AS_L,
               DtackFromDram_L, CAS_Dram_L, RAS_Dram_L,
               DataBusInFromDram, DataBusInFromCache,
        input  FlushBusy_H, DataBusOutTo68k, DataBusOutToDramController,
               DataBusOutToCache, UDS_DramController_L, LDS_DramController_L,
               WE_DramController_L, AS_DramController_L, DramSelectFromCache_L,
               DtackTo68k_L, TagCache_WE_L, DataCache_WE_L, ValidBit_WE_L,
               DataCache_ByteEn_L, AddressBusOutToDramController, TagDataOut,
               Index, WordAddress, ValidBitOut_H, CacheState
    );
endinterface

// File: rtl/m68k_cache_ctrl_param.sv
// Direct-mapped write-through cache controller for the TG68 in front of the
// SDRAM controller. Read misses fill a whole line by SDRAM burst; write hits
// either invalidate or patch the line; Flush_H sweeps every valid bit clear.
module m68k_cache_ctrl_param #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 16,  // 68k bus width, must stay 16
    parameter int INDEX_BITS   = 9,
    parameter int WORD_BITS    = 3,
    parameter int CAS_LATENCY  = 2,
    parameter int WRITE_POLICY = 1    // 0: invalidate on write hit, 1: update
) (
    input  logic Clock,
    input  logic Reset_L,
    m68k_cache_ctrl_param_if.slave bus
);
    localparam int TAG_W   = ADDR_W - INDEX_BITS - WORD_BITS - 1;
    localparam int TAG_LSB = INDEX_BITS + WORD_BITS + 1;
    // One extra bit so BURST can see the count one past the last word.
    localparam int CNT_W   = ((INDEX_BITS > WORD_BITS) ? INDEX_BITS : WORD_BITS) + 1;
    localparam logic [CNT_W-1:0] LAST_LINE  = CNT_W'((1 << INDEX_BITS) - 1);
    localparam logic [CNT_W-1:0] LINE_WORDS = CNT_W'(1 << WORD_BITS);
    localparam logic [CNT_W-1:0] CAS_CNT    = CNT_W'(CAS_LATENCY);

    typedef enum logic [3:0] {
        S_RESET      = 4'd0,
        S_INVALIDATE = 4'd1,
        S_IDLE       = 4'd2,
        S_CHECK_HIT  = 4'd3,
        S_HIT_WAIT   = 4'd4,
        S_MISS_START = 4'd5,
        S_CAS_WAIT   = 4'd6,
        S_BURST      = 4'd7,
        S_END_BURST  = 4'd8,
        S_WRITE_DRAM = 4'd9
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  counter;
    logic              write_hit;
    logic              flush_pend;

    logic [WORD_BITS-1:0]  a_word;
    logic [INDEX_BITS-1:0] a_index;
    logic [TAG_W-1:0]      a_tag;
    logic [DATA_W-1:0]     wr_data;
    logic                  hit, rd_req, wr_req, flush_req;

    assign a_word    = bus.AddressBusInFrom68k[WORD_BITS:1];
    assign a_index   = bus.AddressBusInFrom68k[INDEX_BITS+WORD_BITS:WORD_BITS+1];
    assign a_tag     = bus.AddressBusInFrom68k[ADDR_W-1:TAG_LSB];
    assign wr_data   = bus.DataBusInFrom68k;
    assign hit       = bus.CacheHit_H & bus.ValidBitIn_H;
    assign rd_req    = !bus.AS_L & bus.DramSelect68k_H &  bus.WE_L;
    assign wr_req    = !bus.AS_L & bus.DramSelect68k_H & !bus.WE_L;
    // A flush only starts between bus cycles, never under an active AS_L.
    assign flush_req = (bus.Flush_H | flush_pend) & bus.AS_L;

    // State, shared counter, pending write-hit and latched flush request.
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            state      <= S_RESET;
            counter    <= '0;
            write_hit  <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            // A request seen while already sweeping (or about to) is absorbed.
            if (state == S_RESET || state == S_INVALIDATE)
                flush_pend <= 1'b0;
            else if (bus.Flush_H)
                flush_pend <= 1'b1;

            case (state)
                S_RESET: begin
                    counter <= '0;
                    state   <= S_INVALIDATE;
                end
                S_INVALIDATE: begin
                    if (counter == LAST_LINE) state <= S_IDLE;
                    else                      counter <= counter + 1'b1;
                end
                S_IDLE: begin
                    if (flush_req) begin
                        counter <= '0;
                        state   <= S_INVALIDATE;
                    end else if (rd_req) begin
                        state <= S_CHECK_HIT;
                    end else if (wr_req) begin
                        write_hit <= (WRITE_POLICY != 0) && hit;
                        state     <= S_WRITE_DRAM;
                    end
                end
                S_CHECK_HIT: state <= hit ? S_HIT_WAIT : S_MISS_START;
                S_HIT_WAIT:  if (bus.AS_L) state <= S_IDLE;
                S_MISS_START: begin
                    // CAS without RAS is the read column command, not refresh.
                    if (!bus.CAS_Dram_L && bus.RAS_Dram_L) begin
                        counter <= '0;
                        state   <= S_CAS_WAIT;
                    end
                end
                S_CAS_WAIT: begin
                    if (counter == CAS_CNT) begin
                        counter <= '0;
                        state   <= S_BURST;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                S_BURST: begin
                    if (counter == LINE_WORDS) state <= S_END_BURST;
                    else                       counter <= counter + 1'b1;
                end
                S_END_BURST: if (bus.AS_L || !bus.DramSelect68k_H) state <= S_IDLE;
                S_WRITE_DRAM: begin
                    // Patch the line only once per bus cycle.
                    if (!bus.DtackFromDram_L && write_hit) write_hit <= 1'b0;
                    if (bus.AS_L || !bus.DramSelect68k_H) state <= S_IDLE;
                end
                default: state <= S_RESET;
            endcase
        end
    end

    // Outputs decoded from the current state and live bus inputs.
    always_comb begin
        bus.FlushBusy_H                   = 1'b0;
        bus.DtackTo68k_L                  = 1'b1;
        bus.DramSelectFromCache_L         = 1'b1;
        bus.TagCache_WE_L                 = 1'b1;
        bus.DataCache_WE_L                = 1'b1;
        bus.ValidBit_WE_L                 = 1'b1;
        bus.DataCache_ByteEn_L            = 2'b00;
        bus.ValidBitOut_H                 = 1'b0;
        bus.Index                         = a_index;
        bus.TagDataOut                    = a_tag;
        bus.WordAddress                   = '0;
        bus.UDS_DramController_L          = bus.UDS_L;
        bus.LDS_DramController_L          = bus.LDS_L;
        bus.WE_DramController_L           = bus.WE_L;
        bus.AS_DramController_L           = bus.AS_L;
        bus.AddressBusOutToDramController = {bus.AddressBusInFrom68k[ADDR_W-1:WORD_BITS+1],
                                             {(WORD_BITS+1){1'b0}}};
        bus.DataBusOutTo68k               = bus.DataBusInFromCache;
        bus.DataBusOutToCache             = bus.DataBusInFromDram;
        bus.DataBusOutToDramController    = wr_data;
        bus.CacheState                    = state;

        case (state)
            S_INVALIDATE: begin
                bus.Index         = counter[INDEX_BITS-1:0];
                bus.ValidBit_WE_L = 1'b0;
                bus.FlushBusy_H   = 1'b1;
            end
            S_IDLE: begin
                if (!flush_req && wr_req) begin
                    bus.DramSelectFromCache_L = 1'b0;
                    if (WRITE_POLICY == 0 && bus.ValidBitIn_H)
                        bus.ValidBit_WE_L = 1'b0;
                end
            end
            S_CHECK_HIT: begin
                // Always fetch both bytes so a miss fills whole words.
                bus.UDS_DramController_L = 1'b0;
                bus.LDS_DramController_L = 1'b0;
                if (hit) begin
                    bus.DtackTo68k_L = 1'b0;
                    bus.WordAddress  = a_word;
                end else begin
                    bus.DramSelectFromCache_L = 1'b0;
                end
            end
            S_HIT_WAIT: begin
                bus.DtackTo68k_L = 1'b0;
                bus.WordAddress  = a_word;
            end
            S_MISS_START: begin
                bus.DramSelectFromCache_L = 1'b0;
                bus.TagCache_WE_L         = 1'b0;
                bus.ValidBit_WE_L         = 1'b0;
                bus.ValidBitOut_H         = 1'b1;
            end
            S_CAS_WAIT: bus.DramSelectFromCache_L = 1'b0;
            S_BURST: begin
                bus.DramSelectFromCache_L = 1'b0;
                if (counter < LINE_WORDS) begin
                    bus.WordAddress    = counter[WORD_BITS-1:0];
                    bus.DataCache_WE_L = 1'b0;
                end
            end
            S_END_BURST: begin
                bus.DtackTo68k_L = 1'b0;
                bus.WordAddress  = a_word;
            end
            S_WRITE_DRAM: begin
                bus.AddressBusOutToDramController = bus.AddressBusInFrom68k;
                bus.DramSelectFromCache_L         = 1'b0;
                bus.DtackTo68k_L                  = bus.DtackFromDram_L;
                if (!bus.DtackFromDram_L && write_hit) begin
                    bus.DataCache_WE_L     = 1'b0;
                    bus.DataCache_ByteEn_L = {bus.UDS_L, bus.LDS_L};
                    bus.WordAddress        = a_word;
                    bus.DataBusOutToCache  = wr_data;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_m68k_cache_ctrl_param.sv
// Directed bench for m68k_cache_ctrl_param: an update-policy instance with
// tag/valid/data RAM models, plus an invalidate-policy instance with a
// single valid bit for the write-hit invalidation path.
module tb_m68k_cache_ctrl_param;
    logic Clock   = 1'b0;
    logic Reset_L = 1'b1;
    always #5 Clock = ~Clock;

    m68k_cache_ctrl_param_if #(.ADDR_W(32), .DATA_W(16), .INDEX_BITS(9), .WORD_BITS(3)) bus1 ();
    m68k_cache_ctrl_param_if #(.ADDR_W(32), .DATA_W(16), .INDEX_BITS(9), .WORD_BITS(3)) bus0 ();

    m68k_cache_ctrl_param #(.WRITE_POLICY(1)) dut1 (.Clock(Clock), .Reset_L(Reset_L), .bus(bus1));
    m68k_cache_ctrl_param #(.WRITE_POLICY(0)) dut0 (.Clock(Clock), .Reset_L(Reset_L), .bus(bus0));

    // Cache RAMs for the update-policy instance.
    logic [18:0] tag_ram   [0:511];
    logic        valid_ram [0:511];
    logic [15:0] data_ram  [0:4095];

    assign bus1.CacheHit_H         = (tag_ram[bus1.Index] == bus1.TagDataOut);
    assign bus1.ValidBitIn_H       = valid_ram[bus1.Index];
    assign bus1.DataBusInFromCache = data_ram[{bus1.Index, bus1.WordAddress}];

    // RAM writes for the update-policy instance.
    always @(posedge Clock) begin
        if (!bus1.TagCache_WE_L) tag_ram[bus1.Index] <= bus1.TagDataOut;
        if (!bus1.ValidBit_WE_L) valid_ram[bus1.Index] <= bus1.ValidBitOut_H;
        if (!bus1.DataCache_WE_L) begin
            if (!bus1.DataCache_ByteEn_L[1])
                data_ram[{bus1.Index, bus1.WordAddress}][15:8] <= bus1.DataBusOutToCache[15:8];
            if (!bus1.DataCache_ByteEn_L[0])
                data_ram[{bus1.Index, bus1.WordAddress}][7:0] <= bus1.DataBusOutToCache[7:0];
        end
    end

    // Single valid bit for the invalidate-policy instance.
    logic v0, v0_set;
    assign bus0.ValidBitIn_H = v0;
    always @(posedge Clock) begin
        if (v0_set)                   v0 <= 1'b1;
        else if (!bus0.ValidBit_WE_L) v0 <= bus0.ValidBitOut_H;
    end

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_line [0:7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reset-release sweep: one valid clear per line in order, then IDLE.
    task automatic sweep_check(input string tag);
        int pulses = 0, bad = 0, busy = 0;
        for (int i = 1; i <= 513; i++) begin
            @(negedge Clock);
            if (bus1.FlushBusy_H) busy++;
            if (!bus1.ValidBit_WE_L) begin
                if (bus1.Index != 9'(pulses) || bus1.ValidBitOut_H) bad++;
                pulses++;
            end
        end
        check({tag, " valid pulses"}, pulses, 512);
        check({tag, " index order"}, bad, 0);
        check({tag, " busy clocks"}, busy, 512);
        check({tag, " state idle"}, bus1.CacheState, 2);
        check({tag, " busy low at 514"}, bus1.FlushBusy_H, 0);
        check({tag, " wp0 state idle"}, bus0.CacheState, 2);
    endtask

    initial begin
        int beats, bad, dcyc, tagc, found, busy, pulses;
        bus1.Flush_H = 0; bus1.DramSelect68k_H = 0; bus1.AddressBusInFrom68k = '0;
        bus1.DataBusInFrom68k = '0; bus1.UDS_L = 1; bus1.LDS_L = 1; bus1.WE_L = 1; bus1.AS_L = 1;
        bus1.DtackFromDram_L = 1; bus1.CAS_Dram_L = 1; bus1.RAS_Dram_L = 1; bus1.DataBusInFromDram = '0;
        bus0.Flush_H = 0; bus0.CacheHit_H = 0; bus0.DramSelect68k_H = 0; bus0.AddressBusInFrom68k = '0;
        bus0.DataBusInFrom68k = '0; bus0.UDS_L = 1; bus0.LDS_L = 1; bus0.WE_L = 1; bus0.AS_L = 1;
        bus0.DtackFromDram_L = 1; bus0.CAS_Dram_L = 1; bus0.RAS_Dram_L = 1;
        bus0.DataBusInFromDram = '0; bus0.DataBusInFromCache = '0;
        v0_set = 0;

        // Reset values
        #1 Reset_L = 0;
        @(negedge Clock); @(negedge Clock);
        check("reset state", bus1.CacheState, 0);
        check("reset busy", bus1.FlushBusy_H, 0);
        check("reset strobes", {bus1.DtackTo68k_L, bus1.TagCache_WE_L, bus1.DataCache_WE_L,
                                bus1.ValidBit_WE_L, bus1.DramSelectFromCache_L}, 5'b11111);
        Reset_L = 1;
        sweep_check("init sweep");

        // Cold read miss of 0x0800_0016 (strobes high to see them forced low)
        bus1.AddressBusInFrom68k = 32'h0800_0016; bus1.DramSelect68k_H = 1;
        bus1.WE_L = 1; bus1.AS_L = 0;
        tagc = 0;
        @(negedge Clock);
        check("miss check_hit state", bus1.CacheState, 3);
        check("miss check_hit dramsel", bus1.DramSelectFromCache_L, 0);
        check("miss forced ds", {bus1.UDS_DramController_L, bus1.LDS_DramController_L}, 2'b00);
        check("miss no dtack", bus1.DtackTo68k_L, 1);
        @(negedge Clock);
        if (!bus1.TagCache_WE_L) tagc++;
        check("miss_start state", bus1.CacheState, 5);
        check("miss_start tag/valid we", {bus1.TagCache_WE_L, bus1.ValidBit_WE_L, bus1.ValidBitOut_H}, 3'b001);
        check("miss dram addr", bus1.AddressBusOutToDramController, 32'h0800_0010);
        check("miss tag", bus1.TagDataOut, 19'h4000);
        check("miss index", bus1.Index, 1);
        bus1.CAS_Dram_L = 0;
        @(negedge Clock);
        if (!bus1.TagCache_WE_L) tagc++;
        check("cas_wait state", bus1.CacheState, 6);
        bus1.CAS_Dram_L = 1;
        beats = 0; bad = 0; dcyc = 0;
        for (int cyc = 1; cyc <= 20 && dcyc == 0; cyc++) begin
            @(negedge Clock);
            if (!bus1.TagCache_WE_L) tagc++;
            if (!bus1.DataCache_WE_L) begin
                if (bus1.WordAddress != 3'(beats) || bus1.DataCache_ByteEn_L != 2'b00) bad++;
                if (beats < 8) begin
                    exp_line[beats] = 16'hD000 + 16'(cyc * 17);
                    bus1.DataBusInFromDram = exp_line[beats];
                end
                beats++;
            end
            if (!bus1.DtackTo68k_L) dcyc = cyc;
        end
        check("burst beats", beats, 8);
        check("burst word order", bad, 0);
        check("tag written once", tagc, 1);
        check("miss dtack latency", dcyc, 12);
        check("end_burst state", bus1.CacheState, 8);
        check("end_burst dramsel", bus1.DramSelectFromCache_L, 1);
        check("end_burst word", bus1.WordAddress, 3);
        check("miss read data", bus1.DataBusOutTo68k, exp_line[3]);
        bus1.AS_L = 1;
        @(negedge Clock);
        check("back to idle", bus1.CacheState, 2);

        // Read hit of the same address
        bus1.UDS_L = 0; bus1.LDS_L = 0; bus1.AS_L = 0;
        @(negedge Clock);
        check("hit state", bus1.CacheState, 3);
        check("hit dtack", bus1.DtackTo68k_L, 0);
        check("hit dramsel", bus1.DramSelectFromCache_L, 1);
        check("hit data", bus1.DataBusOutTo68k, exp_line[3]);
        @(negedge Clock);
        check("hit_wait dtack", {bus1.CacheState, bus1.DtackTo68k_L}, {4'd4, 1'b0});
        bus1.AS_L = 1;
        @(negedge Clock);

        // Write hit, lower byte only, update policy
        bus1.AddressBusInFrom68k = 32'h0800_0017; bus1.DataBusInFrom68k = 16'h00A5;
        bus1.UDS_L = 1; bus1.LDS_L = 0; bus1.WE_L = 0; bus1.AS_L = 0;
        #1;
        check("wr idle dramsel", bus1.DramSelectFromCache_L, 0);
        check("wr idle no invalidate", bus1.ValidBit_WE_L, 1);
        @(negedge Clock);
        check("wr state", bus1.CacheState, 9);
        check("wr wait no cache we", {bus1.DataCache_WE_L, bus1.DtackTo68k_L}, 2'b11);
        check("wr full addr", bus1.AddressBusOutToDramController, 32'h0800_0017);
        bus1.DtackFromDram_L = 0;
        #1;
        check("wr cache we", bus1.DataCache_WE_L, 0);
        check("wr byte en", bus1.DataCache_ByteEn_L, 2'b10);
        check("wr word", bus1.WordAddress, 3);
        check("wr data to cache", bus1.DataBusOutToCache, 16'h00A5);
        check("wr dtack", bus1.DtackTo68k_L, 0);
        @(negedge Clock);
        check("wr single update", bus1.DataCache_WE_L, 1);
        bus1.AS_L = 1; bus1.WE_L = 1; bus1.DtackFromDram_L = 1;
        @(negedge Clock);
        check("wr back idle", bus1.CacheState, 2);
        bus1.AddressBusInFrom68k = 32'h0800_0016; bus1.UDS_L = 0; bus1.LDS_L = 0; bus1.AS_L = 0;
        @(negedge Clock);
        check("rd after wr dtack", bus1.DtackTo68k_L, 0);
        check("rd after wr data", bus1.DataBusOutTo68k, {exp_line[3][15:8], 8'hA5});

        // Flush pulsed during a hit cycle
        @(negedge Clock);
        bus1.Flush_H = 1;
        @(negedge Clock);
        bus1.Flush_H = 0;
        check("flush held off", {bus1.CacheState, bus1.FlushBusy_H}, {4'd4, 1'b0});
        bus1.AS_L = 1;
        @(negedge Clock);
        check("flush idle first", bus1.CacheState, 2);
        busy = 0; pulses = 0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge Clock);
            if (bus1.FlushBusy_H) busy++;
            if (!bus1.ValidBit_WE_L) pulses++;
            if (i == 100) bus1.Flush_H = 1;
            if (i == 101) bus1.Flush_H = 0;
        end
        check("flush busy clocks", busy, 512);
        check("flush valid pulses", pulses, 512);
        check("flush end idle", bus1.CacheState, 2);

        // Flushed line misses; reset lands mid-burst at word 4
        bus1.AS_L = 0;
        @(negedge Clock);
        @(negedge Clock);
        check("post flush miss", bus1.CacheState, 5);
        bus1.CAS_Dram_L = 0;
        @(negedge Clock);
        bus1.CAS_Dram_L = 1;
        found = 0;
        for (int cyc = 1; cyc <= 20 && found == 0; cyc++) begin
            @(negedge Clock);
            if (!bus1.DataCache_WE_L && bus1.WordAddress == 3'd4) found = 1;
        end
        check("burst reached word 4", found, 1);
        Reset_L = 0;
        #1;
        check("async reset state", bus1.CacheState, 0);
        check("async reset we", bus1.DataCache_WE_L, 1);
        bus1.AS_L = 1;
        @(negedge Clock);
        Reset_L = 1;
        sweep_check("mid-burst sweep");
        bus1.AS_L = 0;
        @(negedge Clock);
        @(negedge Clock);
        check("after reset miss", bus1.CacheState, 5);

        // Invalidate policy: write to a valid line clears it, next read misses
        v0_set = 1;
        @(negedge Clock);
        v0_set = 0;
        bus0.AddressBusInFrom68k = 32'h0800_0016; bus0.DramSelect68k_H = 1;
        bus0.CacheHit_H = 1; bus0.WE_L = 0; bus0.AS_L = 0;
        #1;
        check("wp0 invalidate we", {bus0.ValidBit_WE_L, bus0.ValidBitOut_H}, 2'b00);
        check("wp0 dramsel", bus0.DramSelectFromCache_L, 0);
        @(negedge Clock);
        check("wp0 write state", bus0.CacheState, 9);
        check("wp0 valid cleared", v0, 0);
        bus0.DtackFromDram_L = 0;
        #1;
        check("wp0 no cache update", {bus0.DtackTo68k_L, bus0.DataCache_WE_L}, 2'b01);
        bus0.AS_L = 1; bus0.WE_L = 1; bus0.DtackFromDram_L = 1;
        @(negedge Clock);
        bus0.AS_L = 0;
        @(negedge Clock);
        check("wp0 read check", {bus0.CacheState, bus0.DtackTo68k_L}, {4'd3, 1'b1});
        @(negedge Clock);
        check("wp0 read misses", bus0.CacheState, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
